// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: req/ack fetch with a bounded timeout, and next-PC/halt selection.
// Optional feature: define PC_ALIGN_CHECK_EN to trap misaligned next-PC targets into the error state.
module pc_fetch_unit #(
  parameter int                     PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0,
  parameter int                     TIMEOUT  = 16
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                PCWre,
  input  logic                PCSrc,
  input  logic [PC_WIDTH-1:0] ext_imm,
  input  logic                exec_done,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_data,
  output logic [PC_WIDTH-1:0] PC,
  output logic [31:0]         inst,
  output logic [5:0]          OpCode,
  output logic                inst_valid,
  output logic                halted,
  output logic                fetch_err
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;
  logic                halted_q, halted_d;
  logic                fetch_err_q, fetch_err_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [PC_WIDTH-1:0] next_pc;
  logic                align_fault;

  // Branch target is relative to the sequential PC; both wrap modulo 2^PC_WIDTH.
  assign next_pc = PCSrc ? (pc_q + PC_WIDTH'(4) + (ext_imm << 2))
                         : (pc_q + PC_WIDTH'(4));

`ifdef PC_ALIGN_CHECK_EN
  assign align_fault = |next_pc[1:0];
`else
  assign align_fault = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      fetch_err_q  <= 1'b0;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
      fetch_err_q  <= fetch_err_d;
      tcnt_q       <= tcnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    halted_d     = halted_q;
    fetch_err_d  = fetch_err_q;
    tcnt_d       = tcnt_q;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      // An ack arriving in the final allowed cycle still wins over the timeout.
      S_FETCH: begin
        if (imem_ack) begin
          inst_d       = imem_data;
          inst_valid_d = 1'b1;
          tcnt_d       = '0;
          state_d      = S_EXEC;
        end else if (tcnt_q == TCNT_LAST) begin
          fetch_err_d  = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = S_ERR;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      S_EXEC: begin
        if (exec_done) begin
          inst_valid_d = 1'b0;
          if (!PCWre) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else if (align_fault) begin
            fetch_err_d = 1'b1;
            state_d     = S_ERR;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end

      S_HALT: state_d = S_HALT;

      S_ERR: begin
        inst_valid_d = 1'b0;
        state_d      = S_ERR;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign PC         = pc_q;
  assign inst       = inst_q;
  assign OpCode     = inst_q[31:26];
  assign inst_valid = inst_valid_q;
  assign halted     = halted_q;
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit (TIMEOUT=4): reset, fetch, next-PC, halt, timeout, wrap and async reset.
module tb_pc_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic        PCWre;
  logic        PCSrc;
  logic [31:0] ext_imm;
  logic        exec_done;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] PC;
  logic [31:0] inst;
  logic [5:0]  OpCode;
  logic        inst_valid;
  logic        halted;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  pc_fetch_unit #(
    .PC_WIDTH(32),
    .RESET_PC(32'h0),
    .TIMEOUT (4)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .PCWre     (PCWre),
    .PCSrc     (PCSrc),
    .ext_imm   (ext_imm),
    .exec_done (exec_done),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .PC        (PC),
    .inst      (inst),
    .OpCode    (OpCode),
    .inst_valid(inst_valid),
    .halted    (halted),
    .fetch_err (fetch_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock and sample just after the active edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset     = 1'b0;
    PCWre     = 1'b0;
    PCSrc     = 1'b0;
    ext_imm   = '0;
    exec_done = 1'b0;
    imem_ack  = 1'b0;
    imem_data = '0;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] d);
    imem_ack  = 1'b1;
    imem_data = d;
    tick();
    imem_ack  = 1'b0;
    imem_data = '0;
  endtask

  task automatic exec(input logic w, input logic s, input logic [31:0] imm);
    PCWre     = w;
    PCSrc     = s;
    ext_imm   = imm;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    PCWre     = 1'b0;
    PCSrc     = 1'b0;
    ext_imm   = '0;
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    PCWre     = 1'b0;
    PCSrc     = 1'b0;
    ext_imm   = '0;
    exec_done = 1'b0;
    imem_ack  = 1'b0;
    imem_data = '0;
    #2 Reset = 1'b0;
    #1;
    checks++; if (PC !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", PC, 32'h0); end
    checks++; if (inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected %h", inst, 32'h0); end
    checks++; if (OpCode !== 6'h0) begin errors++; $display("[TB] FAIL reset_opcode: got %h expected %h", OpCode, 6'h0); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_imem_req: got %b expected 0", imem_req); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_err: got %b expected 0", fetch_err); end
    tick();
    Reset = 1'b1;
    // One idle cycle after release: still no request.
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_req: got %b expected 0", imem_req); end
  endtask

  task automatic test_first_fetch();
    imem_ack  = 1'b1;
    imem_data = 32'h0800_0001;
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL fetch_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL fetch_addr: got %h expected %h", imem_addr, 32'h0); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_early_valid: got %b expected 0", inst_valid); end
    tick();
    imem_ack  = 1'b0;
    imem_data = '0;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid: got %b expected 1", inst_valid); end
    checks++; if (inst !== 32'h0800_0001) begin errors++; $display("[TB] FAIL first_inst: got %h expected %h", inst, 32'h0800_0001); end
    checks++; if (OpCode !== 6'b000010) begin errors++; $display("[TB] FAIL first_opcode: got %b expected 000010", OpCode); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL exec_req: got %b expected 0", imem_req); end
  endtask

  task automatic test_next_pc();
    logic [31:0] exp_addr;
    for (int i = 1; i <= 4; i++) begin
      exp_addr = 32'(i * 4);
      exec(1'b1, 1'b0, 32'h0);
      checks++; if (imem_addr !== exp_addr) begin errors++; $display("[TB] FAIL seq_addr: got %h expected %h", imem_addr, exp_addr); end
      fetch(32'h0);
    end
    exec(1'b1, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("[TB] FAIL seq_0x14: got %h expected %h", imem_addr, 32'h14); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_valid_clear: got %b expected 0", inst_valid); end
    // exec_done while fetching must not move the PC.
    exec(1'b1, 1'b1, 32'h5);
    checks++; if (PC !== 32'h14) begin errors++; $display("[TB] FAIL ignore_exec_pc: got %h expected %h", PC, 32'h14); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL ignore_exec_req: got %b expected 1", imem_req); end
    fetch(32'h0);
    exec(1'b1, 1'b1, 32'h2);
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL branch_fwd: got %h expected %h", imem_addr, 32'h20); end
    fetch(32'h0);
    exec(1'b1, 1'b1, 32'hFFFF_FFFE);
    checks++; if (imem_addr !== 32'h1C) begin errors++; $display("[TB] FAIL branch_back: got %h expected %h", imem_addr, 32'h1C); end
  endtask

  task automatic test_halt();
    fetch(32'hFC00_0000);
    checks++; if (OpCode !== 6'b111111) begin errors++; $display("[TB] FAIL halt_opcode: got %b expected 111111", OpCode); end
    exec(1'b0, 1'b0, 32'h0);
    checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halted: got %b expected 1", halted); end
    checks++; if (PC !== 32'h1C) begin errors++; $display("[TB] FAIL halt_pc: got %h expected %h", PC, 32'h1C); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_valid: got %b expected 0", inst_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_req: got %b expected 0", imem_req); end
    exec(1'b1, 1'b0, 32'h0);
    tick();
    checks++; if (PC !== 32'h1C) begin errors++; $display("[TB] FAIL halt_ignore_pc: got %h expected %h", PC, 32'h1C); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_ignore_req: got %b expected 0", imem_req); end
    checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_hold: got %b expected 1", halted); end
    checks++; if (inst !== 32'hFC00_0000) begin errors++; $display("[TB] FAIL halt_inst: got %h expected %h", inst, 32'hFC00_0000); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    fetch(32'h0);
    exec(1'b1, 1'b1, 32'hFFFF_FFFE);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_neg: got %h expected %h", imem_addr, 32'hFFFF_FFFC); end
    fetch(32'h0);
    exec(1'b1, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_zero: got %h expected %h", imem_addr, 32'h0); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL wrap_err: got %b expected 0", fetch_err); end
  endtask

  task automatic test_timeout();
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) tick();
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early: got %b expected 0", fetch_err); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL timeout_req: got %b expected 1", imem_req); end
    tick();
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b expected 1", fetch_err); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL timeout_req_off: got %b expected 0", imem_req); end
    fetch(32'h1234_5678);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_ack_ignored: got %b expected 0", inst_valid); end
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 1", fetch_err); end
  endtask

  task automatic test_ack_last_cycle();
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) tick();
    fetch(32'h1234_5678);
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL last_ack_err: got %b expected 0", fetch_err); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL last_ack_valid: got %b expected 1", inst_valid); end
    checks++; if (inst !== 32'h1234_5678) begin errors++; $display("[TB] FAIL last_ack_inst: got %h expected %h", inst, 32'h1234_5678); end
    // Counter must restart for the next fetch.
    exec(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    fetch(32'hABCD_0000);
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL tcnt_restart_err: got %b expected 0", fetch_err); end
    checks++; if (inst !== 32'hABCD_0000) begin errors++; $display("[TB] FAIL tcnt_restart_inst: got %h expected %h", inst, 32'hABCD_0000); end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick();
    fetch(32'h0);
    exec(1'b1, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL pre_async_req: got %b expected 1", imem_req); end
    #2 Reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL async_req: got %b expected 0", imem_req); end
    checks++; if (PC !== 32'h0) begin errors++; $display("[TB] FAIL async_pc: got %h expected %h", PC, 32'h0); end
    tick();
    Reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_next_pc();
    test_halt();
    test_wrap();
    test_timeout();
    test_ack_last_cycle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
